speck_round_encrypt: RTL and testbench
======================================

// Module: speck_round_encrypt
// PURPOSE
//  Speck128 round datapath; consumer of the key schedule's per-round key output.
//  - Accepts a 128-bit block {x,y} and a 64-bit round key.
//  - Applies one Speck round (ROR8 / add / xor / ROL3 / xor) as a multi-cycle FSM.
//  - Returns the result with a one-cycle finished pulse.
//  - The encryption top alternates key_schedule_encrypt and this block once per round.
// PARAMETERS
//  WORD_W   64  word width of x, y and round key (block = 2*WORD_W)
//  ROT_X    8   right-rotate amount applied to x (left-rotate on decrypt)
//  ROT_Y    3   left-rotate amount applied to y (right-rotate on decrypt)
// PORTS
//  clk            in   1    system clock, rising edge
//  rst_n          in   1    asynchronous active-low reset
//  signal_start   in   1    request; accepted only in IDLE
//  block_in       in   128  [127:64]=x, [63:0]=y
//  round_key      in   64   round key k (key schedule outKey[127:64])
//  block_out      out  128  result {x',y'}
//  finished       out  1    one-cycle pulse, block_out valid
//  busy           out  1    high in every state except IDLE
//  state_response out  3    current FSM state encoding
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset: state=IDLE, block_out=0, finished=0, busy=0, internal x/y/k=0.
//  - FSM: IDLE(0) -> ROR_X(1) -> ADD_XY(2) -> XOR_K_ROL_Y(3) -> XOR_Y(4) -> OUTPUT(5) -> IDLE.
//    - IDLE: if signal_start, latch x, y, k from inputs on the same edge and go to ROR_X.
//    - ROR_X: x <= ROR(x,ROT_X).
//    - ADD_XY: x <= x + y, mod 2^64 (carry discarded).
//    - XOR_K_ROL_Y: x <= x ^ k and y <= ROL(y,ROT_Y), both on the same edge.
//    - XOR_Y: y <= y ^ x, using the x value after the key xor.
//    - OUTPUT: block_out <= {x,y}; finished <= 1; go to IDLE.
//  - finished is cleared on every edge not in OUTPUT, so it is exactly one cycle.
//  - Latency: accept edge E0 -> finished and block_out valid after edge E0+5.
//  - Throughput: one round per 6 cycles. A new start can be accepted in the cycle finished is high.
//  - block_out holds its value until the next OUTPUT or reset.
//  - Inputs are sampled only at the accept edge; later changes have no effect.
//  - signal_start while busy is ignored, not queued. Requester must re-assert after finished.
//  - Rotations are true rotations, not shifts; rotate amounts are constants, so no zero-amount case arises.
//  - rst_n asserted mid-round: round is abandoned immediately. No finished pulse; block_out=0.
//  - state encodings 6,7 are unreachable; if entered, next edge -> IDLE, no output update.
// CONFIGURATION
//  SPECK_DECRYPT_EN defined:
//    - Adds input port decrypt (1 bit), sampled at the accept edge.
//    - decrypt=1 runs the inverse round through the same 6-state sequence and latency:
//      - ROR_X: y <= x ^ y.
//      - ADD_XY: y <= ROR(y,ROT_Y).
//      - XOR_K_ROL_Y: x <= x ^ k.
//      - XOR_Y: x <= ROL(x - y, ROT_X), subtraction mod 2^64.
//      - OUTPUT: as for encrypt.
//    - decrypt=0 behaves exactly as the encrypt round.
//  SPECK_DECRYPT_EN undefined: no decrypt port; encrypt-only datapath, no subtractor.
// TESTING
//  1. Reset: rst_n=0, then release -> block_out=0, finished=0, busy=0, state_response=0.
//  2. Encrypt x=0x100, y=0, k=0 -> after 5 edges: block_out={64'h1,64'h1}, finished 1 cycle.
//  3. Encrypt x=0, y=1, k=0xFF -> block_out={64'hFE,64'hF6}.
//  4. Add wrap: x=0xFF, y=64'h0100_0000_0000_0000, k=0 -> block_out={64'h0,64'h0800_0000_0000_0000}.
//  5. start held high and block_in changed during a round -> result of first latched inputs only.
//     Next round starts on the edge where finished=1. rst_n pulsed in ADD_XY -> IDLE, no finished.
//  6. (SPECK_DECRYPT_EN) decrypt=1, block_in={64'h1,64'h1}, k=0 -> block_out={64'h100,64'h0}.

Source files
------------

// File: rtl/speck_round_encrypt.sv
// Speck128 single-round datapath, one primitive step per FSM state, 6 cycles per round.
// Optional inverse round is compiled in when SPECK_DECRYPT_EN is defined (adds the decrypt port).
module speck_round_encrypt #(
   parameter int WORD_W = 64,
   parameter int ROT_X  = 8,
   parameter int ROT_Y  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  signal_start,
`ifdef SPECK_DECRYPT_EN
   input  logic                  decrypt,
`endif
   input  logic [2*WORD_W-1:0]   block_in,
   input  logic [WORD_W-1:0]     round_key,
   output logic [2*WORD_W-1:0]   block_out,
   output logic                  finished,
   output logic                  busy,
   output logic [2:0]            state_response
);

   // Handshake: signal_start is sampled only while IDLE; block_in, round_key (and decrypt)
   // are captured on that same edge. finished is a one-cycle strobe qualifying block_out,
   // and busy is high from the accept edge until the edge that raises finished.

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ROR_X       = 3'd1,
      ST_ADD_XY      = 3'd2,
      ST_XOR_K_ROL_Y = 3'd3,
      ST_XOR_Y       = 3'd4,
      ST_OUTPUT      = 3'd5
   } state_t;

   state_t              state_q;
   logic [WORD_W-1:0]   x_q;
   logic [WORD_W-1:0]   y_q;
   logic [WORD_W-1:0]   k_q;
`ifdef SPECK_DECRYPT_EN
   logic                dec_q;
`endif

   function automatic logic [WORD_W-1:0] rot_r(input logic [WORD_W-1:0] v, input int n);
      return (v >> n) | (v << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] rot_l(input logic [WORD_W-1:0] v, input int n);
      return (v << n) | (v >> (WORD_W - n));
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         k_q       <= '0;
         block_out <= '0;
         finished  <= 1'b0;
`ifdef SPECK_DECRYPT_EN
         dec_q     <= 1'b0;
`endif
      end else begin
         finished <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (signal_start) begin
                  x_q     <= block_in[2*WORD_W-1:WORD_W];
                  y_q     <= block_in[WORD_W-1:0];
                  k_q     <= round_key;
`ifdef SPECK_DECRYPT_EN
                  dec_q   <= decrypt;
`endif
                  state_q <= ST_ROR_X;
               end
            end

            ST_ROR_X: begin
`ifdef SPECK_DECRYPT_EN
               if (dec_q) begin
                  y_q <= x_q ^ y_q;
               end else begin
                  x_q <= rot_r(x_q, ROT_X);
               end
`else
               x_q <= rot_r(x_q, ROT_X);
`endif
               state_q <= ST_ADD_XY;
            end

            ST_ADD_XY: begin
`ifdef SPECK_DECRYPT_EN
               if (dec_q) begin
                  y_q <= rot_r(y_q, ROT_Y);
               end else begin
                  x_q <= x_q + y_q;
               end
`else
               x_q <= x_q + y_q;
`endif
               state_q <= ST_XOR_K_ROL_Y;
            end

            ST_XOR_K_ROL_Y: begin
               x_q <= x_q ^ k_q;
`ifdef SPECK_DECRYPT_EN
               if (!dec_q) begin
                  y_q <= rot_l(y_q, ROT_Y);
               end
`else
               y_q <= rot_l(y_q, ROT_Y);
`endif
               state_q <= ST_XOR_Y;
            end

            // Encrypt mixes the keyed x into y; decrypt undoes the add and the x rotation.
            ST_XOR_Y: begin
`ifdef SPECK_DECRYPT_EN
               if (dec_q) begin
                  x_q <= rot_l(x_q - y_q, ROT_X);
               end else begin
                  y_q <= y_q ^ x_q;
               end
`else
               y_q <= y_q ^ x_q;
`endif
               state_q <= ST_OUTPUT;
            end

            ST_OUTPUT: begin
               block_out <= {x_q, y_q};
               finished  <= 1'b1;
               state_q   <= ST_IDLE;
            end

            // Encodings 6 and 7 recover to IDLE without touching block_out.
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy           = (state_q != ST_IDLE);
   assign state_response = state_q;

endmodule

// File: tb/tb_speck_round_encrypt.sv
// Directed bench for speck_round_encrypt: driver pushes expected blocks, monitor pops on finished.
module tb_speck_round_encrypt;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         signal_start = 1'b0;
   logic [127:0] block_in = '0;
   logic [63:0]  round_key = '0;
   logic [127:0] block_out;
   logic         finished;
   logic         busy;
   logic [2:0]   state_response;
`ifdef SPECK_DECRYPT_EN
   logic         decrypt = 1'b0;
`endif

   speck_round_encrypt dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .signal_start   (signal_start),
`ifdef SPECK_DECRYPT_EN
      .decrypt        (decrypt),
`endif
      .block_in       (block_in),
      .round_key      (round_key),
      .block_out      (block_out),
      .finished       (finished),
      .busy           (busy),
      .state_response (state_response)
   );

   // clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [127:0] exp_q[$];
   int           acc_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor: data and latency (finished seen 5 edges after accept)
   logic [127:0] mon_exp;
   int           mon_acc;
   logic         prev_fin = 1'b0;
   always @(negedge clk) begin
      if (rst_n && finished) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_finished: got block_out %h with no round pending", block_out);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_acc = acc_q.pop_front();
            chk("block_out", block_out, mon_exp);
            chk("latency", 128'(cyc), 128'(mon_acc + 5));
         end
         if (prev_fin) begin
            checks++;
            errors++;
            $display("FAIL finished_width: got finished high 2 cycles, expected 1");
         end
      end
      prev_fin = finished;
   end

   // driver: one full round, inputs scrambled after the accept edge
   task automatic run(input logic [127:0] blk, input logic [63:0] k, input logic [127:0] exp);
      @(negedge clk);
      block_in     = blk;
      round_key    = k;
      signal_start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
      signal_start = 1'b0;
      block_in     = {$urandom, $urandom, $urandom, $urandom};
      round_key    = {$urandom, $urandom};
      chk("busy_in_round", busy, 1);
      chk("state_ror_x", state_response, 1);
      repeat (6) @(posedge clk);
   endtask

   initial begin
      // reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_block_out", block_out, 0);
      chk("reset_finished", finished, 0);
      chk("reset_busy", busy, 0);
      chk("reset_state", state_response, 0);

      // basic encrypt vectors
      run({64'h100, 64'h0}, 64'h0, {64'h1, 64'h1});
      run({64'h0, 64'h1}, 64'hFF, {64'hFE, 64'hF6});
      run({64'hFF, 64'h0100_0000_0000_0000}, 64'h0,
          {64'h0, 64'h0800_0000_0000_0000});

      // start held high; inputs change mid-round; back-to-back accept on finished cycle
      @(negedge clk);
      block_in     = {64'h100, 64'h0};
      round_key    = 64'h0;
      signal_start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back({64'h1, 64'h1});
      acc_q.push_back(cyc);
      block_in  = {64'h0, 64'h1};
      round_key = 64'hFF;
      repeat (4) @(posedge clk);
      #1;
      chk("held_start_ignored", state_response, 5);
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back({64'hFE, 64'hF6});
      acc_q.push_back(cyc);
      signal_start = 1'b0;
      chk("back_to_back_accept", state_response, 1);
      repeat (6) @(posedge clk);

      // reset mid-round in ADD_XY
      @(negedge clk);
      block_in     = {64'h100, 64'h0};
      round_key    = 64'h0;
      signal_start = 1'b1;
      @(posedge clk);
      #1;
      signal_start = 1'b0;
      @(posedge clk);
      #1;
      chk("state_add_xy", state_response, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_state", state_response, 0);
      chk("midreset_block_out", block_out, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_finished", finished, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);

      // recovery after reset, different key pattern
      run({64'h0, 64'h1}, 64'hFF, {64'hFE, 64'hF6});

`ifdef SPECK_DECRYPT_EN
      decrypt = 1'b1;
      run({64'h1, 64'h1}, 64'h0, {64'h100, 64'h0});
      decrypt = 1'b0;
      run({64'h100, 64'h0}, 64'h0, {64'h1, 64'h1});
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("all_rounds_finished", 128'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
